// File: rtl/rr_grant_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// rr_grant_scheduler_pkg
//
// Shared definitions for the four-way round-robin grant scheduler:
//   - state_e      : scheduler state (IDLE, GRANT)
//   - NUM_REQ      : number of requesters sharing the resource
//   - IDX_W        : width of a requester index
//   - decode_idx() : 2-to-4 decoder with enable, used to build the one-hot
//                    grant vector from the registered grant index
// ----------------------------------------------------------------------------
package rr_grant_scheduler_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // One-hot decode of an index; all zero when the enable is low, so the
  // result can never be multi-hot.
  function automatic logic [NUM_REQ-1:0] decode_idx(input logic [IDX_W-1:0] idx,
                                                    input logic             enable);
    logic [NUM_REQ-1:0] onehot;
    onehot = '0;
    if (enable) begin
      onehot[idx] = 1'b1;
    end
    return onehot;
  endfunction

endpackage

// File: rtl/rr_grant_scheduler_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
//
// Purely combinational rotating-priority search. Starting at ptr and walking
// ptr, ptr+1, ptr+2, ptr+3 (mod 4), it reports the first asserted request.
//
// Ports:
//   req   in  [3:0]  request lines, bit i = requester i
//   ptr   in  [1:0]  highest-priority index
//   valid out        at least one request is asserted
//   idx   out [1:0]  first requester found in search order (ptr when !valid)
// ----------------------------------------------------------------------------
module rr_pick
  import rr_grant_scheduler_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;

  // Walk the four positions in priority order; the first hit wins because
  // later hits are masked by valid already being set.
  always_comb begin
    valid = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ptr + IDX_W'(k);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_grant_scheduler.sv
// ----------------------------------------------------------------------------
// rr_grant_scheduler
//
// Shares one resource among four requesters. A grant is held until the owner
// signals done or drops its request, after which priority rotates to the
// requester after the owner so no one starves. Every release passes through
// at least one IDLE cycle before the next grant.
//
// Parameters:
//   TIMEOUT_CYCLES  maximum grant length (2..255), only with GRANT_TIMEOUT_EN
//
// Ports:
//   clk        in        rising-edge clock
//   reset      in        synchronous, active-high reset
//   en         in        arbitration enable (gates new grants only)
//   req        in  [3:0] request lines
//   done       in        release strobe from the current owner
//   grant      out [3:0] one-hot grant, zero when idle
//   grant_idx  out [1:0] index of current or last owner
//   busy       out       high while a grant is held
//   timeout    out       one-cycle pulse after a forced release
//
// Build option:
//   GRANT_TIMEOUT_EN  when defined, an 8-bit hold counter force-releases a
//                     grant after TIMEOUT_CYCLES cycles; otherwise timeout
//                     is tied low and grants are held indefinitely.
// ----------------------------------------------------------------------------
module rr_grant_scheduler
  import rr_grant_scheduler_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               busy,
  output logic               timeout
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("rr_grant_scheduler: TIMEOUT_CYCLES must be within 2..255");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic             release_normal;
  logic             release_forced;

  rr_pick u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // done and a dropped owner request are the same kind of release; both may
  // be true in one cycle and still count as a single release.
  assign release_normal = done | ~req[grant_idx_q];

`ifdef GRANT_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] hold_q, hold_d;
  logic       timeout_q;

  // Counter sits at zero in IDLE, so the first GRANT cycle sees zero and the
  // last allowed cycle sees TIMEOUT_CYCLES-1.
  assign hold_d = (state_q == GRANT) ? hold_q + 8'd1 : 8'd0;

  // Expiry only counts as forced when no normal cause is present, which
  // keeps timeout low when done coincides with expiry.
  assign release_forced = (hold_q == HOLD_LAST) & ~release_normal;

  // The pulse is registered on the releasing edge, so it appears during the
  // first IDLE cycle and lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= (state_q == GRANT) & release_forced;
    end
  end

  assign timeout = timeout_q;
`else
  assign release_forced = 1'b0;
  assign timeout        = 1'b0;
`endif

  // State, grant index and priority pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_idx_q <= '0;
      ptr_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      ptr_q       <= ptr_d;
    end
  end

  // Next-state logic. IDLE only grants when enabled; GRANT ignores en and
  // other requesters until the owner releases, then hands priority to the
  // index just after the owner (2-bit wrap makes 3 roll over to 0).
  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    ptr_d       = ptr_q;
    case (state_q)
      IDLE: begin
        if (en && pick_valid) begin
          state_d     = GRANT;
          grant_idx_d = pick_idx;
        end
      end
      GRANT: begin
        if (release_normal || release_forced) begin
          state_d = IDLE;
          ptr_d   = grant_idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs come straight from registers; grant is a decode of the
  // registered index enabled by the registered busy state.
  assign busy      = (state_q == GRANT);
  assign grant_idx = grant_idx_q;
  assign grant     = decode_idx(grant_idx_q, busy);

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// ----------------------------------------------------------------------------
// tb_rr_grant_scheduler
//
// Self-checking bench for rr_grant_scheduler. Directed steps reproduce the
// scheduler's intended scenarios, followed by randomized traffic. Expected
// outputs come from a behavioural model that tracks the owner as an integer
// and searches requests by modular arithmetic. Honours GRANT_TIMEOUT_EN.
// ----------------------------------------------------------------------------
module tb_rr_grant_scheduler;

  localparam int TO = 4;

  logic       clk;
  logic       reset;
  logic       en;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int errors = 0;
  int stepNum = 0;

  // Behavioural model: owner = -1 when idle.
  int mOwner = -1;
  int mPtr = 0;
  int mIdx = 0;
  int mHold = 0;
  bit mTimeout = 1'b0;

  rr_grant_scheduler #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .req       (req),
    .done      (done),
    .grant     (grant),
    .grant_idx (grant_idx),
    .busy      (busy),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic modelUpdate(input logic r, input logic e, input logic [3:0] q, input logic d);
    bit normalRel;
    bit expired;
    if (r) begin
      mOwner = -1;
      mPtr = 0;
      mIdx = 0;
      mHold = 0;
      mTimeout = 1'b0;
    end else if (mOwner < 0) begin
      mTimeout = 1'b0;
      if (e && q != 4'b0000) begin
        for (int k = 0; k < 4; k++) begin
          if (mOwner < 0 && q[(mPtr + k) % 4]) begin
            mOwner = (mPtr + k) % 4;
          end
        end
        mIdx = mOwner;
        mHold = 0;
      end
    end else begin
      normalRel = d || !q[mOwner];
`ifdef GRANT_TIMEOUT_EN
      expired = (mHold + 1 >= TO);
`else
      expired = 1'b0;
`endif
      if (normalRel || expired) begin
        mPtr = (mOwner + 1) % 4;
        mOwner = -1;
        mTimeout = expired && !normalRel;
      end else begin
        mHold = mHold + 1;
        mTimeout = 1'b0;
      end
    end
  endtask

  // Compare every output against the model.
  task automatic checkOutput();
    logic [3:0] expGrant;
    logic [1:0] expIdx;
    logic expBusy;
    logic expTimeout;
    expGrant = (mOwner >= 0) ? 4'(1 << mOwner) : 4'b0000;
    expIdx = 2'(mIdx);
    expBusy = (mOwner >= 0);
    expTimeout = mTimeout;

    checks++;
    assert (grant === expGrant) else begin
      errors++;
      $error("[TB] FAIL grant step %0d: observed %b expected %b", stepNum, grant, expGrant);
    end
    checks++;
    assert (grant_idx === expIdx) else begin
      errors++;
      $error("[TB] FAIL grant_idx step %0d: observed %0d expected %0d", stepNum, grant_idx, expIdx);
    end
    checks++;
    assert (busy === expBusy) else begin
      errors++;
      $error("[TB] FAIL busy step %0d: observed %b expected %b", stepNum, busy, expBusy);
    end
    checks++;
    assert (timeout === expTimeout) else begin
      errors++;
      $error("[TB] FAIL timeout step %0d: observed %b expected %b", stepNum, timeout, expTimeout);
    end
  endtask

  // Drive one cycle of inputs, clock it, update the model, then check.
  task automatic applyStimulus(input logic r, input logic e, input logic [3:0] q, input logic d);
    reset = r;
    en = e;
    req = q;
    done = d;
    @(posedge clk);
    modelUpdate(r, e, q, d);
    #1;
    stepNum++;
    checkOutput();
  endtask

  initial begin
    reset = 1'b1;
    en = 1'b0;
    req = 4'b0000;
    done = 1'b0;
    @(negedge clk);

    // Reset state.
    applyStimulus(1'b1, 1'b0, 4'b0000, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'b0000, 1'b0);

    // Single request from owner 2, done pulse, then ptr=3 picks owner 3.
    applyStimulus(1'b0, 1'b1, 4'b0100, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b0100, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b0100, 1'b1);
    applyStimulus(1'b0, 1'b1, 4'b1111, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b1111, 1'b1);
    applyStimulus(1'b0, 1'b1, 4'b0000, 1'b0);

    // Done while idle has no effect.
    applyStimulus(1'b0, 1'b1, 4'b0000, 1'b1);

    // Fairness: all requesting, done pulsed on each grant.
    applyStimulus(1'b1, 1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 4'b1111, 1'b0);
      applyStimulus(1'b0, 1'b1, 4'b1111, 1'b1);
    end
    applyStimulus(1'b0, 1'b1, 4'b0000, 1'b0);

    // Owner 1 granted, en dropped: grant kept until done, then IDLE waits.
    applyStimulus(1'b0, 1'b1, 4'b0010, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'b0010, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'b0010, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'b0010, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'b0010, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'b0010, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b0010, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b0010, 1'b1);

    // Owner 3 released with req=1001: next grant wraps to owner 0.
    applyStimulus(1'b0, 1'b1, 4'b1000, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b1001, 1'b1);
    applyStimulus(1'b0, 1'b1, 4'b1001, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b1001, 1'b1);

    // Owner 2 holds with no done (forced release only with the timeout build).
    applyStimulus(1'b0, 1'b1, 4'b0000, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b0100, 1'b0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b1, 4'b1100, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 4'b1100, 1'b1);
    applyStimulus(1'b0, 1'b1, 4'b0000, 1'b0);

    // Owner drops its request without done.
    applyStimulus(1'b0, 1'b1, 4'b0001, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b0110, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b0110, 1'b0);

    // Reset mid-grant of owner 1, then all requesting grants owner 0.
    applyStimulus(1'b1, 1'b0, 4'b0000, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b0010, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'b0010, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b1111, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b1111, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 59) == 0),
                    ($urandom_range(0, 3) != 0),
                    4'($urandom_range(0, 15)),
                    ($urandom_range(0, 3) == 0));
    end

    // Long holds mixed in to reach expiry in the timeout build.
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'b0, 1'b1, ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'b1111,
                    ($urandom_range(0, 9) == 0));
    end

    $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_grant_scheduler.md
# rr_grant_scheduler

Round-robin scheduler that shares one resource among four requesters and drives a one-hot grant vector from a registered 2-bit grant index. The index is decoded 2-to-4 with the enable tied to the busy state. The block sits between the requesting units and the shared resource. It holds each grant until the owner signals completion, then rotates priority so no requester starves.

## Interface
Parameters:
- TIMEOUT_CYCLES, 8: maximum grant length in cycles. Used only when the timeout feature is compiled in. Legal range 2..255.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- en  in  1  arbitration enable; gates new grants only
- req  in  4  request lines; bit i = requester i
- done  in  1  release strobe from the current owner; ignored when not busy
- grant  out  4  one-hot grant; all zero when idle
- grant_idx  out  2  index of current or last owner
- busy  out  1  high while a grant is held
- timeout  out  1  one-cycle pulse on forced release; constant 0 without the feature

## Operation
- Reset values: state=IDLE, grant=4'b0000, grant_idx=2'd0, busy=0, timeout=0, ptr=2'd0.
- ptr is the highest-priority index. The search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
- IDLE:
  - If en=1 and req!=0, select the first set req bit in search order.
  - Register it into grant_idx and go to GRANT.
  - Otherwise stay in IDLE, with grant_idx holding its old value.
- GRANT:
  - busy=1 and grant = decode(grant_idx).
  - Release occurs when any of the following holds: done=1, req[grant_idx]=0, or timeout expiry (feature only).
  - On release: go to IDLE, set ptr = grant_idx+1 (2-bit wrap: 3 -> 0), clear grant and busy.
- en=0 during GRANT does not preempt; the current grant runs to release.
- Requests from non-owners during GRANT are ignored until the next IDLE evaluation.
- done and req drop in the same cycle count as a single release.
- done=1 while IDLE has no effect.
- grant is always one-hot or zero; it is never multi-hot.

## Timing
- Grant latency: a request sampled in IDLE at edge N produces grant and busy high after edge N. One cycle of latency.
- Release: done sampled at edge M clears grant after edge M.
- Turnaround: IDLE is occupied for at least one cycle after each release. The earliest next grant appears after edge M+1. A continuously requesting set of owners therefore sees a 1-cycle dead gap.
- Fairness: with all four req held high and done pulsed every grant, owners cycle 0,1,2,3,0 with no repeats.
- Reset asserted mid-grant: all outputs reach their reset values after that edge. No release pulse, and ptr returns to 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- GRANT_TIMEOUT_EN defined:
  - An 8-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When the count reaches TIMEOUT_CYCLES-1 without another release cause, the grant is force-released. timeout pulses high for exactly one cycle, in the first IDLE cycle, and ptr advances as for a normal release.
  - If done and expiry coincide, the release is treated as normal and timeout=0.
- GRANT_TIMEOUT_EN undefined: no counter is built, timeout is tied to 0, and a grant is held indefinitely.

## Structure
- Shared package holds:
  - state enum {IDLE, GRANT}
  - NUM_REQ=4
  - IDX_W=2
- Sub-module rr_pick is combinational: inputs req[3:0] and ptr[1:0]; outputs valid and idx[1:0], implementing the rotating priority search.
- The top level holds the FSM, ptr, the optional counter, and the 2-to-4 decode of grant_idx enabled by busy.

## Test plan
- Reset, then req=4'b0100, en=1 → one cycle later grant=4'b0100, grant_idx=2, busy=1. After a done pulse, grant=0, and ptr=3 is visible on the next selection.
- req=4'b1111 held, done pulsed each grant cycle → grant sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
- Owner 1 granted, en dropped to 0 → grant is kept until done. Afterwards IDLE persists, with req pending, until en=1.
- Owner 3 granted and released with req=4'b1001 → next grant is 0001 (wrap), not 1000.
- With GRANT_TIMEOUT_EN and TIMEOUT_CYCLES=4, owner 2 holds req with no done → grant drops after 4 GRANT cycles, timeout pulses for 1 cycle, and the next grant goes to owner 3 if it is requesting.
- Reset asserted while grant=4'b0010 → after the edge, grant=0, busy=0, grant_idx=0, timeout=0; after reset, req=4'b1111 grants owner 0.
